// File: rtl/conv1_pkg.sv
// Shared constants and state encoding for the Convolution 1 layer sequencer.
package conv1_pkg;
    localparam int IMG_W   = 28;
    localparam int KS      = 5;
    localparam int OUT_W   = 24;
    localparam int N_TAPS  = 25;
    localparam int K1_BASE = 25;
    localparam int IMG_AW  = 10;
    localparam int OUT_AW  = 10;
    localparam int K_AW    = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_K_DRAIN,
        S_CONV,
        S_C_DRAIN,
        S_WRITE,
        S_DONE
    } conv1_state_t;
endpackage

// File: rtl/conv1_win_addr.sv
// Window walker: r/c/tap counters with incremental image and output addressing.
module conv1_win_addr
    import conv1_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step_tap,
    input  logic              step_pos,
    output logic [IMG_AW-1:0] img_addr,
    output logic [OUT_AW-1:0] out_addr,
    output logic [4:0]        tap_idx,
    output logic              last_tap,
    output logic              last_pos
);
    logic [4:0]        r_q, r_d, c_q, c_d, tap_q, tap_d;
    logic [2:0]        j_q, j_d;
    logic [IMG_AW-1:0] base_q, base_d, img_q, img_d;
    logic [OUT_AW-1:0] oaddr_q, oaddr_d;

    assign last_tap = (tap_q == 5'(N_TAPS - 1));
    assign last_pos = (r_q == 5'(OUT_W - 1)) && (c_q == 5'(OUT_W - 1));
    assign img_addr = img_q;
    assign out_addr = oaddr_q;
    assign tap_idx  = tap_q;

    always_comb begin
        r_d     = r_q;
        c_d     = c_q;
        tap_d   = tap_q;
        j_d     = j_q;
        base_d  = base_q;
        img_d   = img_q;
        oaddr_d = oaddr_q;
        if (clear || (step_pos && last_pos)) begin
            // Final position parks everything at zero so no counter runs past its range.
            r_d     = '0;
            c_d     = '0;
            tap_d   = '0;
            j_d     = '0;
            base_d  = '0;
            img_d   = '0;
            oaddr_d = '0;
        end else if (step_pos) begin
            if (c_q == 5'(OUT_W - 1)) begin
                c_d    = '0;
                r_d    = r_q + 1'b1;
                base_d = base_q + IMG_AW'(IMG_W - OUT_W + 1);
            end else begin
                c_d    = c_q + 1'b1;
                base_d = base_q + 1'b1;
            end
            img_d   = base_d;
            oaddr_d = oaddr_q + 1'b1;
            tap_d   = '0;
            j_d     = '0;
        end else if (step_tap) begin
            if (last_tap) begin
                tap_d = '0;
                j_d   = '0;
                img_d = base_q;
            end else if (j_q == 3'(KS - 1)) begin
                j_d   = '0;
                tap_d = tap_q + 1'b1;
                img_d = img_q + IMG_AW'(IMG_W - KS + 1);
            end else begin
                j_d   = j_q + 1'b1;
                tap_d = tap_q + 1'b1;
                img_d = img_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            c_q     <= '0;
            tap_q   <= '0;
            j_q     <= '0;
            base_q  <= '0;
            img_q   <= '0;
            oaddr_q <= '0;
        end else begin
            r_q     <= r_d;
            c_q     <= c_d;
            tap_q   <= tap_d;
            j_q     <= j_d;
            base_q  <= base_d;
            img_q   <= img_d;
            oaddr_q <= oaddr_d;
        end
    end
endmodule

// File: rtl/conv1_sched.sv
// Convolution 1 layer sequencer: kernel load, window walk, MAC control and result write.
module conv1_sched
    import conv1_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              k_rd_en,
    output logic [K_AW-1:0]   k_addr0,
    output logic [K_AW-1:0]   k_addr1,
    output logic              k_load_en,
    output logic [4:0]        k_load_idx,
    output logic              img_rd_en,
    output logic [IMG_AW-1:0] img_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic [4:0]        mac_idx,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_addr
);
    conv1_state_t state_q, state_d;
    logic [4:0]   t_q, t_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         win_clear, step_tap, step_pos, last_tap, last_pos;
    logic [4:0]   tap_idx;

    logic [RD_LAT-1:0] kv_q, kv_d, mv_q, mv_d;
    logic [4:0]        ki_q [RD_LAT];
    logic [4:0]        ki_d [RD_LAT];
    logic [4:0]        mi_q [RD_LAT];
    logic [4:0]        mi_d [RD_LAT];

    conv1_win_addr u_win (
        .clk      (clk),
        .reset    (reset),
        .clear    (win_clear),
        .step_tap (step_tap),
        .step_pos (step_pos),
        .img_addr (img_addr),
        .out_addr (out_addr),
        .tap_idx  (tap_idx),
        .last_tap (last_tap),
        .last_pos (last_pos)
    );

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        cnt_d     = cnt_q;
        win_clear = 1'b0;
        step_tap  = 1'b0;
        step_pos  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        k_rd_en   = 1'b0;
        img_rd_en = 1'b0;
        out_we    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (state_q == S_DONE);
                if (start) begin
                    state_d   = S_LOAD_K;
                    t_d       = '0;
                    win_clear = 1'b1;
                end
            end
            S_LOAD_K: begin
                k_rd_en = 1'b1;
                if (t_q == 5'(N_TAPS - 1)) begin
                    t_d     = '0;
                    cnt_d   = '0;
                    state_d = S_K_DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_K_DRAIN, S_C_DRAIN: begin
                // Wait out the memory latency so the last tap lands before moving on.
                if (cnt_q == 2'(RD_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_K_DRAIN) ? S_CONV : S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CONV: begin
                img_rd_en = 1'b1;
                step_tap  = 1'b1;
                if (last_tap) begin
                    cnt_d   = '0;
                    state_d = S_C_DRAIN;
                end
            end
            S_WRITE: begin
                out_we = 1'b1;
                if (out_ready) begin
                    step_pos = 1'b1;
                    state_d  = last_pos ? S_DONE : S_CONV;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        kv_d[0] = k_rd_en;
        ki_d[0] = k_rd_en ? t_q : '0;
        mv_d[0] = img_rd_en;
        mi_d[0] = img_rd_en ? tap_idx : '0;
        for (int n = 1; n < RD_LAT; n++) begin
            kv_d[n] = kv_q[n-1];
            ki_d[n] = ki_q[n-1];
            mv_d[n] = mv_q[n-1];
            mi_d[n] = mi_q[n-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            kv_q    <= '0;
            mv_q    <= '0;
            for (int n = 0; n < RD_LAT; n++) begin
                ki_q[n] <= '0;
                mi_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            kv_q    <= kv_d;
            mv_q    <= mv_d;
            for (int n = 0; n < RD_LAT; n++) begin
                ki_q[n] <= ki_d[n];
                mi_q[n] <= mi_d[n];
            end
        end
    end

    assign k_addr0    = k_rd_en ? K_AW'(t_q) : '0;
    assign k_addr1    = k_rd_en ? (K_AW'(K1_BASE) + K_AW'(t_q)) : '0;
    assign k_load_en  = kv_q[RD_LAT-1];
    assign k_load_idx = ki_q[RD_LAT-1];
    assign mac_en     = mv_q[RD_LAT-1];
    assign mac_idx    = mi_q[RD_LAT-1];
    assign mac_clr    = mac_en && (mac_idx == 5'd0);
endmodule

// File: tb/tb_conv1_sched.sv
// Directed bench for conv1_sched: window table, kernel load, backpressure, start/reset control.
module tb_conv1_sched;
    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       out_ready = 1'b1;
    logic       busy, done, k_rd_en, k_load_en, img_rd_en, mac_en, mac_clr, out_we;
    logic [5:0] k_addr0, k_addr1;
    logic [4:0] k_load_idx, mac_idx;
    logic [9:0] img_addr, out_addr;
    logic       any_out;

    conv1_sched #(.RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .k_rd_en    (k_rd_en),
        .k_addr0    (k_addr0),
        .k_addr1    (k_addr1),
        .k_load_en  (k_load_en),
        .k_load_idx (k_load_idx),
        .img_rd_en  (img_rd_en),
        .img_addr   (img_addr),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .mac_idx    (mac_idx),
        .out_we     (out_we),
        .out_addr   (out_addr)
    );

    always #5 clk = ~clk;

    assign any_out = |{busy, done, k_rd_en, k_addr0, k_addr1, k_load_en, k_load_idx,
                       img_rd_en, img_addr, mac_en, mac_clr, mac_idx, out_we, out_addr};

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor state (written only by the monitor process)
    logic mon_clr = 1'b0;
    int   wp, cur_tap, addr_err, mac_err, mac_exp, wr_err, wr_cnt;
    int   krd_cnt, kld_cnt, k_err, stall_seen, m_r, m_c, m_e;
    logic prev_krd, prev_img;
    int   pos_first [576];
    int   pos_last  [576];
    int   pos_oaddr [576];
    int   krd_a0 [25];
    int   krd_a1 [25];

    always @(negedge clk) begin
        if (mon_clr) begin
            wp = 0; cur_tap = 0; addr_err = 0; mac_err = 0; mac_exp = 0;
            wr_err = 0; wr_cnt = 0; krd_cnt = 0; kld_cnt = 0; k_err = 0;
            stall_seen = 0; prev_krd = 1'b0; prev_img = 1'b0;
            for (int p = 0; p < 576; p++) begin
                pos_first[p] = -1; pos_last[p] = -1; pos_oaddr[p] = -1;
            end
        end else begin
            if (k_rd_en) begin
                if (krd_cnt < 25) begin
                    krd_a0[krd_cnt] = int'(k_addr0);
                    krd_a1[krd_cnt] = int'(k_addr1);
                end
                krd_cnt++;
            end
            if (k_load_en) begin
                if (!prev_krd || int'(k_load_idx) != kld_cnt) k_err++;
                kld_cnt++;
            end else if (prev_krd) begin
                k_err++;
            end
            if (img_rd_en) begin
                m_r = wp / 24;
                m_c = wp % 24;
                m_e = (m_r + cur_tap / 5) * 28 + m_c + cur_tap % 5;
                if (wp < 576) begin
                    if (cur_tap == 0) pos_first[wp] = int'(img_addr);
                    pos_last[wp] = int'(img_addr);
                end
                if (int'(img_addr) != m_e || cur_tap > 24) addr_err++;
                cur_tap++;
            end
            if (mac_en != prev_img) mac_err++;
            if (mac_en) begin
                if (int'(mac_idx) != mac_exp || mac_clr != (mac_idx == 5'd0)) mac_err++;
                mac_exp = (mac_exp + 1) % 25;
            end else if (mac_clr) begin
                mac_err++;
            end
            if (out_we) begin
                if (int'(out_addr) != wp || cur_tap != 25 || img_rd_en) wr_err++;
                if (!out_ready) begin
                    stall_seen++;
                end else begin
                    if (wp < 576) pos_oaddr[wp] = int'(out_addr);
                    wp++;
                    cur_tap = 0;
                    wr_cnt++;
                end
            end
            prev_krd = k_rd_en;
            prev_img = img_rd_en;
        end
    end

    // Backpressure generator: five stalled cycles on the write of position 7
    logic stall_en = 1'b0;
    int   stall_cnt = 0;
    always @(posedge clk) begin
        #2;
        if (stall_en && out_we && wp == 7 && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
        end else begin
            out_ready = 1'b1;
        end
    end

    typedef struct {
        int pos;
        int first;
        int last;
        int oaddr;
    } win_vec_t;
    win_vec_t tbl [6];

    task automatic check_windows(input string tag);
        for (int v = 0; v < 6; v++) begin
            check($sformatf("%s pos%0d first", tag, tbl[v].pos), pos_first[tbl[v].pos], tbl[v].first);
            check($sformatf("%s pos%0d last", tag, tbl[v].pos), pos_last[tbl[v].pos], tbl[v].last);
            check($sformatf("%s pos%0d out_addr", tag, tbl[v].pos), pos_oaddr[tbl[v].pos], tbl[v].oaddr);
        end
    endtask

    task automatic check_run(input string tag);
        int kseq_err;
        kseq_err = 0;
        for (int t = 0; t < 25; t++)
            if (krd_a0[t] != t || krd_a1[t] != 25 + t) kseq_err++;
        check({tag, " k_addr0 first"}, krd_a0[0], 0);
        check({tag, " k_addr1 first"}, krd_a1[0], 25);
        check({tag, " k_addr0 last"}, krd_a0[24], 24);
        check({tag, " k_addr1 last"}, krd_a1[24], 49);
        check({tag, " k_addr seq errors"}, kseq_err, 0);
        check({tag, " k_rd count"}, krd_cnt, 25);
        check({tag, " k_load count"}, kld_cnt, 25);
        check({tag, " k_load timing/idx errors"}, k_err, 0);
        check({tag, " img_addr errors"}, addr_err, 0);
        check({tag, " mac errors"}, mac_err, 0);
        check({tag, " write errors"}, wr_err, 0);
        check({tag, " write count"}, wr_cnt, 576);
        check_windows(tag);
    endtask

    task automatic run_layer(input string tag, input int poke_start, output int lat);
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, " done cleared at start"}, done, 0);
        check({tag, " busy at start"}, busy, 1);
        lat = -1;
        for (int n = 1; n <= 20000; n++) begin
            @(posedge clk); #1;
            if (poke_start != 0 && n == 300) start = 1'b1;
            if (poke_start != 0 && n == 303) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) $display("FAIL %s done timeout: got none, expected within 20000 cycles", tag);
    endtask

    int lat;

    initial begin
        tbl[0] = '{pos: 0,   first: 0,   last: 116, oaddr: 0};
        tbl[1] = '{pos: 7,   first: 7,   last: 123, oaddr: 7};
        tbl[2] = '{pos: 23,  first: 23,  last: 139, oaddr: 23};
        tbl[3] = '{pos: 24,  first: 28,  last: 144, oaddr: 24};
        tbl[4] = '{pos: 300, first: 348, last: 464, oaddr: 300};
        tbl[5] = '{pos: 575, first: 667, last: 783, oaddr: 575};

        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check($sformatf("idle outputs cycle %0d", n), any_out, 0);
        end

        // Run 1: backpressure at position 7 and stray start pulses mid-run
        stall_en = 1'b1;
        run_layer("run1", 1, lat);
        check("run1 latency", lat, 15578 + 5);
        check("run1 stall cycles", stall_seen, 5);
        check_run("run1");
        check("run1 busy in done", busy, 0);
        repeat (5) @(posedge clk);
        #1 check("run1 done held", done, 1);

        // Run 2: restart from DONE, no stall
        stall_en = 1'b0;
        run_layer("run2", 0, lat);
        check("run2 latency", lat, 15578);
        check("run2 stall cycles", stall_seen, 0);
        check_run("run2");

        // Run 3: reset asserted mid-CONV
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 check("run3 reading before reset", img_rd_en, 1);
        #2 reset = 1'b0;
        #1 check("run3 outputs after async reset", any_out, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check($sformatf("run3 quiet after reset %0d", n), any_out, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv1_sched.md
Name: conv1_sched

Overview:
- Top-level sequencer for the Convolution 1 layer.
- After `start`, it reads both 5x5 kernels from conv1 weight memory into the MAC weight registers.
- It then walks all 24x24 output positions of the 28x28 input image. For each position it issues 25 image reads, drives the MAC enable/clear, and writes one result per position to output memory.
- `done` is a level flag held high until the next `start`.

Parameters:
- IMG_W, 28, input image width/height in pixels
- KS, 5, kernel side length
- OUT_W, 24, output width/height (IMG_W-KS+1)
- RD_LAT, 1, read latency in cycles of kernel and image memories (1..3)
- K1_BASE, 25, weight memory base address of kernel 1 (kernel 0 base is 0)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (asserts on reset=0)
- start  in  1  begin layer; sampled only in IDLE
- out_ready  in  1  output memory can accept a write this cycle
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  sticky completion flag
- k_rd_en  out  1  weight memory read strobe
- k_addr0  out  6  kernel 0 weight address
- k_addr1  out  6  kernel 1 weight address
- k_load_en  out  1  weight data valid; latch into weight registers
- k_load_idx  out  5  tap index (0..24) for k_load_en
- img_rd_en  out  1  image memory read strobe
- img_addr  out  10  image address, row*IMG_W+col
- mac_en  out  1  image data valid; accumulate
- mac_clr  out  1  with mac_en: load instead of accumulate (first tap)
- mac_idx  out  5  tap index matching mac_en
- out_we  out  1  output write request
- out_addr  out  10  output address, r*OUT_W+c (0..575)

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0, including done, addresses, indices and internal counters.
- States: IDLE, LOAD_K, K_DRAIN, CONV, C_DRAIN, WRITE, DONE.
- IDLE, start=1: go to LOAD_K. done cleared on the same edge.
- DONE, start=1: clear done and go to LOAD_K. In all other states start is ignored.
- LOAD_K, 25 cycles:
  - k_rd_en=1.
  - k_addr0 = t; k_addr1 = K1_BASE+t, for t = 0..24.
  - After t=24, go to K_DRAIN.
- K_DRAIN, RD_LAT cycles: k_rd_en=0. Then go to CONV with r=c=0.
- k_load_en/k_load_idx: k_rd_en/t delayed exactly RD_LAT cycles through a valid shift register. The last k_load_en occurs in the final K_DRAIN cycle.
- CONV, 25 cycles per output position:
  - img_rd_en=1.
  - img_addr = (r+i)*IMG_W + (c+j), taps in row-major order i,j = 0..4.
  - Address generation is incremental: +1 within a row, +IMG_W-KS+1 at row end. No multiplier.
  - After the last tap, go to C_DRAIN.
- C_DRAIN, RD_LAT cycles, then WRITE.
- mac_en/mac_idx: img_rd_en/tap index delayed RD_LAT cycles. mac_clr = mac_en && mac_idx==0.
- WRITE:
  - out_we=1 and out_addr = r*OUT_W+c (held stable) until a cycle with out_ready=1.
  - On that edge the write completes: c increments. At c=23, c wraps to 0 and r increments.
  - At (r,c)=(23,23), go to DONE; otherwise go to CONV.
  - out_we stays high during the out_ready=0 stall. No reads are issued during the stall.
- DONE: done=1, busy=0, all strobes 0.
- Timing with out_ready constantly 1:
  - LOAD_K+K_DRAIN = 25+RD_LAT cycles.
  - Each position = 25+RD_LAT+1 cycles.
  - For RD_LAT=1, done rises 26+576*27 = 15578 cycles after the start-sampling edge.
- Reset mid-operation: immediate return to IDLE. No write is issued after reset.
- Widths:
  - r, c are 5 bits; tap counter is 5 bits.
  - img_addr max 783 fits 10 bits; out_addr max 575 fits 10 bits.
  - No wrap is permitted; the counters must never exceed these bounds.

Decomposition:
- Package conv1_pkg holds:
  - constants IMG_W, KS, OUT_W, N_TAPS=25, K1_BASE, IMG_AW=10, OUT_AW=10, K_AW=6;
  - the state enum typedef (conv1_state_t).
- Sub-module conv1_win_addr: the r/c/i/j counters and incremental img_addr/out_addr generation.
  - Inputs: clear, step_tap, step_pos.
  - Outputs: img_addr, out_addr, last_tap, last_pos.
- The FSM, latency shift registers and weight-load addressing stay in conv1_sched.

Test Plan:
- Reset/idle: hold reset=0, then release with start=0 for 10 cycles. Required: all outputs 0, busy=0, done=0.
- Weight load, RD_LAT=1, start pulse:
  - k_addr0/k_addr1 read 0/25 in the first cycle and 24/49 in the 25th.
  - k_load_en asserted 25 consecutive cycles, each one cycle after its k_rd_en; k_load_idx 0..24.
- First window: img_addr sequence 0,1,2,3,4,28,...,116 (25 values). mac_clr only with mac_idx=0. out_we with out_addr=0.
- Window addressing:
  - Position (0,23): addresses 23..139.
  - Position (1,0): first address 28.
  - Position (23,23): addresses 667..783, out_addr=575.
  - done then rises with total latency 15578 cycles.
- Backpressure: out_ready=0 for 5 cycles at position 7. out_we and out_addr=7 held, no img_rd_en. Advance on the first out_ready=1 cycle.
- Control robustness:
  - start pulses while busy are ignored.
  - reset=0 mid-CONV returns to IDLE with out_we=0.
  - start after DONE clears done and repeats the sequence identically.
